// File: rtl/ldtu_gain_select.sv
// Gain selector: delays gain-1/gain-10 samples and emits gain-1 data around gain-10 saturation.
// Optional macro LDTU_GSEL_FORCEG1_EN adds input force_g1 to force gain-1 per sample.
module ldtu_gain_select #(
    parameter int Nbits_12  = 12,
    parameter int PRE_DEPTH = 8
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic [Nbits_12-1:0] DATA_gain_01,
    input  logic [Nbits_12-1:0] DATA_gain_10,
    input  logic [Nbits_12-1:0] SATURATION_value,
    input  logic                win_len,
`ifdef LDTU_GSEL_FORCEG1_EN
    input  logic                force_g1,
`endif
    output logic [Nbits_12:0]   DATA_out,
    output logic                data_valid,
    output logic                SeuError
);

    localparam int CW = ($clog2(PRE_DEPTH + 16) < 5) ? 5 : $clog2(PRE_DEPTH + 16);
    localparam int FW = $clog2(PRE_DEPTH + 2);
    localparam logic [CW-1:0] LOAD_S   = CW'(PRE_DEPTH + 7);
    localparam logic [CW-1:0] LOAD_L   = CW'(PRE_DEPTH + 15);
    localparam logic [FW-1:0] FILL_END = FW'(PRE_DEPTH + 1);

    logic [Nbits_12-1:0]                r_g01_in, r_g10_in;
    logic                               r_win_in;
    logic [PRE_DEPTH-1:0][Nbits_12-1:0] r_g01_d, r_g10_d;
    logic [CW-1:0]                      r_cnt;
    logic [FW-1:0]                      r_fill;

    logic          w_sat, w_flag, w_frc;
    logic [CW-1:0] w_cnt_nxt;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_g01_in <= '0;
            r_g10_in <= '0;
            r_win_in <= 1'b0;
            r_g01_d  <= '0;
            r_g10_d  <= '0;
        end else begin
            r_g01_in   <= DATA_gain_01;
            r_g10_in   <= DATA_gain_10;
            r_win_in   <= win_len;
            r_g01_d[0] <= r_g01_in;
            r_g10_d[0] <= r_g10_in;
            for (int i = 1; i < PRE_DEPTH; i++) begin
                r_g01_d[i] <= r_g01_d[i-1];
                r_g10_d[i] <= r_g10_d[i-1];
            end
        end
    end

`ifdef LDTU_GSEL_FORCEG1_EN
    // Force bit rides alongside its sample so it lands on that sample's output slot.
    logic [PRE_DEPTH:0] r_frc;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_frc <= '0;
        end else begin
            r_frc[0] <= force_g1;
            for (int i = 1; i <= PRE_DEPTH; i++) r_frc[i] <= r_frc[i-1];
        end
    end

    assign w_frc = r_frc[PRE_DEPTH];
`else
    assign w_frc = 1'b0;
`endif

    // A saturated sample at the input stage lines up with sample s-PRE_DEPTH at the
    // delay-line tail, so the window opens on the current output and the counter
    // holds how many further outputs stay gain-1.
    always_comb begin
        w_sat     = (r_g10_in >= SATURATION_value);
        w_cnt_nxt = r_cnt;
        if (w_sat)
            w_cnt_nxt = r_win_in ? LOAD_L : LOAD_S;
        else if (r_cnt != '0)
            w_cnt_nxt = r_cnt - 1'b1;
        w_flag = w_sat | (r_cnt != '0) | w_frc;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            DATA_out   <= '0;
            data_valid <= 1'b0;
            r_cnt      <= '0;
            r_fill     <= '0;
        end else begin
            DATA_out   <= {w_flag, w_flag ? r_g01_d[PRE_DEPTH-1] : r_g10_d[PRE_DEPTH-1]};
            r_cnt      <= w_cnt_nxt;
            data_valid <= (r_fill == FILL_END);
            if (r_fill != FILL_END)
                r_fill <= r_fill + 1'b1;
        end
    end

    assign SeuError = 1'b0;

endmodule

// File: tb/tb_ldtu_gain_select.sv
// Directed bench for ldtu_gain_select: table of saturation scenarios plus reset-abort sequence.
module tb_ldtu_gain_select;

    localparam int NS = 50;

    typedef struct {
        logic [11:0] thr;
        int          s1;
        int          s2;
        logic [11:0] satv;
        logic        w1;
        logic        w2;
        int          flo;
        int          fhi;
        int          lo;
        int          hi;
    } vec_t;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] g01 = '0, g10 = '0, thr = 12'hFFF;
    logic        win_len = 1'b0;
`ifdef LDTU_GSEL_FORCEG1_EN
    logic        force_g1 = 1'b0;
`endif
    logic [12:0] dout;
    logic        data_valid, seu;

    int checks = 0;
    int errors = 0;
    vec_t tbl[10];

    ldtu_gain_select dut (
        .CLK              (CLK),
        .rst              (rst),
        .DATA_gain_01     (g01),
        .DATA_gain_10     (g10),
        .SATURATION_value (thr),
        .win_len          (win_len),
`ifdef LDTU_GSEL_FORCEG1_EN
        .force_g1         (force_g1),
`endif
        .DATA_out         (dout),
        .data_valid       (data_valid),
        .SeuError         (seu)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] g01_of(input int n);
        return 12'h100 + 12'(n);
    endfunction

    function automatic logic [11:0] g10_of(input vec_t v, input int n);
        if (n == v.s1 || n == v.s2) return v.satv;
        return 12'(n);
    endfunction

    task automatic drive(input vec_t v, input int n);
        g01     = g01_of(n);
        g10     = g10_of(v, n);
        win_len = (n == v.s2) ? v.w2 : v.w1;
`ifdef LDTU_GSEL_FORCEG1_EN
        force_g1 = (n >= v.flo && n <= v.fhi);
`endif
    endtask

    // Leaves the bench at the negedge where rst drops; the next posedge captures sample 0.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          m;
        logic        flag;
        logic [12:0] exp;
        thr = v.thr;
        drive(v, 0);
        do_reset();
        for (int e = 1; e <= NS + 9; e++) begin
            drive(v, e - 1);
            @(posedge CLK);
            @(negedge CLK);
            if (e < 10) begin
                chk($sformatf("v%0d valid_low e%0d", id, e), 13'(data_valid), 13'd0);
            end else begin
                m    = e - 10;
                flag = (m >= v.lo && m <= v.hi);
                exp  = {flag, flag ? g01_of(m) : g10_of(v, m)};
                chk($sformatf("v%0d out s%0d", id, m), dout, exp);
                chk($sformatf("v%0d valid s%0d", id, m), 13'(data_valid), 13'd1);
            end
        end
    endtask

    initial begin
        vec_t vq;
        //          thr      s1  s2  satv     w1    w2    flo fhi lo  hi
        tbl[0] = '{12'hFFF, -1, -1, 12'h000, 1'b0, 1'b0, -1, -2, 1,  0};
        tbl[1] = '{12'h800, 20, -1, 12'h900, 1'b0, 1'b0, -1, -2, 12, 27};
        tbl[2] = '{12'h800, 20, 25, 12'h900, 1'b0, 1'b1, -1, -2, 12, 40};
        tbl[3] = '{12'h800, 20, -1, 12'h900, 1'b1, 1'b0, -1, -2, 12, 35};
        tbl[4] = '{12'h800, 20, 27, 12'h900, 1'b1, 1'b0, -1, -2, 12, 34};
        tbl[5] = '{12'h000, -1, -1, 12'h000, 1'b0, 1'b0, -1, -2, 0,  1000};
        tbl[6] = '{12'hFFF, 30, -1, 12'hFFF, 1'b0, 1'b0, -1, -2, 22, 37};
        tbl[7] = '{12'h900, 5,  -1, 12'h900, 1'b0, 1'b0, -1, -2, 0,  12};
        tbl[8] = '{12'h901, 5,  -1, 12'h900, 1'b0, 1'b0, -1, -2, 1,  0};
`ifdef LDTU_GSEL_FORCEG1_EN
        tbl[9] = '{12'hFFF, -1, -1, 12'h000, 1'b0, 1'b0, 30, 33, 30, 33};
`else
        tbl[9] = '{12'hFFF, -1, -1, 12'h000, 1'b0, 1'b0, 30, 33, 1,  0};
`endif

        #1;
        chk("reset dout", dout, 13'd0);
        chk("reset valid", 13'(data_valid), 13'd0);
        chk("seu tied", 13'(seu), 13'd0);

        for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

        // Reset lands mid-window right after sample 15 is output.
        vq  = tbl[1];
        thr = vq.thr;
        drive(vq, 0);
        do_reset();
        for (int e = 1; e <= 25; e++) begin
            drive(vq, e - 1);
            @(posedge CLK);
            @(negedge CLK);
        end
        chk("abort pre s15", dout, {1'b1, g01_of(15)});
        rst = 1'b1;
        #1;
        chk("abort async dout", dout, 13'd0);
        chk("abort async valid", 13'(data_valid), 13'd0);
        @(posedge CLK);
        @(negedge CLK);
        rst = 1'b0;
        vq = tbl[0];
        vq.thr = 12'h800;
        thr = vq.thr;
        for (int e = 1; e <= 30; e++) begin
            drive(vq, e - 1);
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("abort flag e%0d", e), 13'(dout[12]), 13'd0);
            chk($sformatf("abort valid e%0d", e), 13'(data_valid), (e >= 10) ? 13'd1 : 13'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldtu_gain_select.md
LDTU_GAIN_SELECT -- requirements
Module: ldtu_gain_select

Interface
REQ-001 The block SHALL have parameter Nbits_12, default 12, meaning the sample width.
REQ-002 The block SHALL have parameter PRE_DEPTH, default 8, meaning the number of pre-saturation samples in the gain-1 window.
REQ-003 Port CLK  input  1  the single block clock; all state SHALL change on its rising edge only.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port DATA_gain_01  input  Nbits_12  baseline-subtracted gain-1 sample, one per CLK.
REQ-006 Port DATA_gain_10  input  Nbits_12  baseline-subtracted gain-10 sample, one per CLK.
REQ-007 Port SATURATION_value  input  Nbits_12  gain-10 saturation threshold, quasi-static.
REQ-008 Port win_len  input  1  post-window length select: 0 -> 7 samples, 1 -> 15 samples.
REQ-009 Port DATA_out  output  Nbits_12+1  bit 12 = gain flag (1 = gain-1), bits 11:0 = selected sample.
REQ-010 Port data_valid  output  1  high when DATA_out carries a sample that has passed the full delay line.
REQ-011 Port SeuError  output  1  tied 1'b0.

Function
REQ-012 Both inputs SHALL be registered every CLK; sample s is the pair captured on edge k.
REQ-013 Sample s SHALL appear on DATA_out after edge k+PRE_DEPTH+1 (9 cycles at default), via a PRE_DEPTH-stage shift register per gain.
REQ-014 Sample s SHALL be saturated iff its registered gain-10 value >= SATURATION_value (unsigned compare).
REQ-015 If sample s is saturated, samples s-PRE_DEPTH through s+P (P = 7 or 15 per win_len) SHALL be output with flag 1 and gain-1 data.
REQ-016 All other samples SHALL be output with flag 0 and gain-10 data.
REQ-017 A saturated sample inside an active window SHALL retrigger the window: the post-window end moves to s+P of the newest saturated sample.
REQ-018 win_len SHALL be sampled with each saturated sample; changes affect only subsequent triggers.
REQ-019 Window tracking SHALL use a down-counter of width >= 5 bits that saturates at 0 and never wraps.
REQ-020 SATURATION_value = 0 SHALL make every sample gain-1; 12'hFFF SHALL trigger only on 12'hFFF.
REQ-021 Pre-window samples that entered before reset release do not exist, so those positions SHALL simply not be output.
REQ-022 data_valid SHALL rise after edge PRE_DEPTH+1 following reset release and stay high until next reset.
REQ-023 The 13-bit DATA_out SHALL be registered and glitch-free.

Reset
REQ-024 While rst is high: DATA_out = 0, data_valid = 0, delay lines = 0, window counter = 0, fill counter = 0.
REQ-025 rst asserted mid-window SHALL abort the window immediately; no gain-1 flag SHALL appear after release until a new saturation.
REQ-026 Reset assertion SHALL take effect without a CLK edge; release SHALL be synchronised by the integrator upstream.

Configuration
REQ-027 Macro LDTU_GSEL_FORCEG1_EN, when defined, SHALL add input force_g1 (1 bit) after win_len.
REQ-028 With the macro defined, every sample captured while force_g1 = 1 SHALL be output with flag 1 and gain-1 data, independent of saturation; window counting SHALL continue unaffected.
REQ-029 Without the macro, the port SHALL be absent and behaviour SHALL equal force_g1 = 0.

Verification
REQ-030 Threshold 12'hFFF, g10 ramp 0..100, g01 = 5 -> all outputs flag 0, data = ramp, first valid output 9 cycles after reset release.
REQ-031 Threshold 12'h800, single g10 = 12'h900 at sample 20, win_len 0 -> samples 12..27 flagged 1 with g01 data; samples 11 and 28 flagged 0.
REQ-032 Same as REQ-031 with a second saturated sample 25, win_len 1 -> samples 12..40 flagged 1, with no gap.
REQ-033 Saturated sample 20, rst pulsed at output of sample 15 -> DATA_out = 0 and data_valid = 0 asynchronously; after release, no flag 1 until a new saturation.
REQ-034 Threshold 0 -> every valid output has flag 1; with LDTU_GSEL_FORCEG1_EN, threshold 12'hFFF, force_g1 high for samples 30..33 -> exactly those four samples are flagged 1.
